// File: rtl/queue_2x115_if.sv
// queue_2x115_if: ready/valid handshake bundle for the two-entry queue.
// The slave modport is the queue side and the master modport is the user side.
interface queue_2x115_if #(
  parameter int WIDTH = 115,
  parameter int DEPTH = 2
);
  logic                     enq_valid;
  logic                     enq_ready;
  logic [WIDTH-1:0]         enq_bits;
  logic                     deq_valid;
  logic                     deq_ready;
  logic [WIDTH-1:0]         deq_bits;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  enq_valid,
    input  enq_bits,
    input  deq_ready,
    output enq_ready,
    output deq_valid,
    output deq_bits,
    output count
  );

  modport master (
    output enq_valid,
    output enq_bits,
    output deq_ready,
    input  enq_ready,
    input  deq_valid,
    input  deq_bits,
    input  count
  );
endinterface

// File: rtl/queue_2x115.sv
// queue_2x115: two-entry 115-bit ready/valid FIFO with a combinational read port.
// Optional macro QUEUE_FLOW_EN: when defined, an empty queue passes the
// producer payload straight through to the consumer in the same cycle.
module queue_2x115 #(
  parameter int WIDTH = 115,
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  queue_2x115_if.slave io
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
  logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
  logic             maybe_full_q, maybe_full_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic ptr_match;
  logic empty;
  logic full;
  logic do_enq;
  logic do_deq;
  logic flow_pass;
  logic wr_fire;
  logic rd_fire;

  // Status derived from the registered pointers and the wrap flag.
  always_comb begin
    ptr_match = (enq_ptr_q == deq_ptr_q);
    empty     = ptr_match & ~maybe_full_q;
    full      = ptr_match &  maybe_full_q;
  end

  // Handshake outputs, read port and occupancy.
  always_comb begin
    io.enq_ready = ~full;
`ifdef QUEUE_FLOW_EN
    io.deq_valid = ~empty | io.enq_valid;
    io.deq_bits  = empty ? io.enq_bits : mem_q[deq_ptr_q];
`else
    io.deq_valid = ~empty;
    io.deq_bits  = mem_q[deq_ptr_q];
`endif
    io.count     = full ? CW'(DEPTH) : {1'b0, enq_ptr_q - deq_ptr_q};
  end

  // Fire decode; a flow-through transfer touches neither storage nor pointers.
  always_comb begin
    do_enq = io.enq_valid & io.enq_ready;
    do_deq = io.deq_valid & io.deq_ready;
`ifdef QUEUE_FLOW_EN
    flow_pass = empty & io.enq_valid & io.deq_ready;
`else
    flow_pass = 1'b0;
`endif
    wr_fire = do_enq & ~flow_pass;
    rd_fire = do_deq & ~flow_pass;
  end

  // Next-state for pointers and the wrap flag.
  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (wr_fire) enq_ptr_d = enq_ptr_q + PW'(1);
    if (rd_fire) deq_ptr_d = deq_ptr_q + PW'(1);
    if (wr_fire != rd_fire) maybe_full_d = wr_fire;
  end

  // Control state register with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Payload storage; not reset, contents become stale when control is cleared.
  always_ff @(posedge clock) begin
    if (wr_fire) mem_q[enq_ptr_q] <= io.enq_bits;
  end

endmodule

// File: tb/tb_queue_2x115.sv
// tb_queue_2x115: directed and randomized checks of queue_2x115 against a
// queue-based reference model.
module tb_queue_2x115;

  localparam int WIDTH = 115;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq [$];

  queue_2x115_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) io ();

  queue_2x115 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (io)
  );

  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] rand_payload();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  // Compare outputs against what the model says for the current inputs.
  task automatic check_outputs(input string tag);
    logic             exp_ready;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_bits;
    logic [2:0]       exp_count;
    exp_ready = (mq.size() < DEPTH);
    exp_count = 3'(mq.size());
    exp_valid = (mq.size() > 0);
    exp_bits  = (mq.size() > 0) ? mq[0] : '0;
`ifdef QUEUE_FLOW_EN
    if (mq.size() == 0 && io.enq_valid) begin
      exp_valid = 1'b1;
      exp_bits  = io.enq_bits;
    end
`endif
    checks++;
    assert (io.enq_ready === exp_ready) else begin
      errors++;
      $error("FAIL %s enq_ready obs=%0b exp=%0b", tag, io.enq_ready, exp_ready);
    end
    checks++;
    assert (io.deq_valid === exp_valid) else begin
      errors++;
      $error("FAIL %s deq_valid obs=%0b exp=%0b", tag, io.deq_valid, exp_valid);
    end
    checks++;
    assert ({1'b0, io.count} === exp_count) else begin
      errors++;
      $error("FAIL %s count obs=%0d exp=%0d", tag, io.count, exp_count);
    end
    if (exp_valid) begin
      checks++;
      assert (io.deq_bits === exp_bits) else begin
        errors++;
        $error("FAIL %s deq_bits obs=%h exp=%h", tag, io.deq_bits, exp_bits);
      end
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, then advance model.
  task automatic step(input logic ev, input logic [WIDTH-1:0] eb,
                      input logic dr, input string tag);
    logic en, de, pass;
    @(negedge clock);
    io.enq_valid = ev;
    io.enq_bits  = eb;
    io.deq_ready = dr;
    #1;
    check_outputs(tag);
    en   = ev && (mq.size() < DEPTH);
    pass = 1'b0;
`ifdef QUEUE_FLOW_EN
    pass = ev && dr && (mq.size() == 0);
`endif
    de   = dr && (mq.size() > 0);
    @(posedge clock);
    if (!pass) begin
      if (de) void'(mq.pop_front());
      if (en) mq.push_back(eb);
    end
  endtask

  initial begin
    io.enq_valid = 1'b0;
    io.enq_bits  = '0;
    io.deq_ready = 1'b0;

    // Reset state.
    #12;
    check_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Fill to full, then hold a payload while full.
    step(1'b1, WIDTH'(1), 1'b0, "fill1");
    step(1'b1, WIDTH'(2), 1'b0, "fill2");
    step(1'b1, WIDTH'(3), 1'b0, "full_hold");
    step(1'b1, WIDTH'(3), 1'b0, "full_hold2");
    // Dequeue while full: enq_ready must stay low this cycle.
    step(1'b1, WIDTH'(3), 1'b1, "full_deq");
    step(1'b1, WIDTH'(3), 1'b0, "reopen");
    step(1'b0, '0, 1'b1, "drain2");
    step(1'b0, '0, 1'b1, "drain3");
    step(1'b0, '0, 1'b1, "drained");

    // Reset asserted mid-cycle with one entry stored.
    step(1'b1, WIDTH'(32'h55), 1'b0, "pre_reset");
    @(negedge clock);
    io.enq_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    check_outputs("mid_reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Streaming: continuous enqueue and dequeue.
    for (int i = 0; i < 100; i++) step(1'b1, WIDTH'(i), 1'b1, "stream");
    step(1'b0, '0, 1'b1, "stream_tail");
    step(1'b0, '0, 1'b0, "stream_empty");

    // Empty queue with producer and consumer both ready.
    step(1'b1, WIDTH'(32'h7FF), 1'b1, "flow");
    step(1'b0, '0, 1'b1, "flow_next");
    step(1'b0, '0, 1'b0, "flow_empty");

    // Random stress.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), rand_payload(), 1'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
